// File: rtl/pc_fetch_gen.sv
// pc_fetch_gen: IF-stage fetch-address generator with a valid/ready request
// channel, bounded outstanding-request tracking, pending-branch hold, and
// flush redirect that marks in-flight responses as stale.
module pc_fetch_gen #(
  parameter int                ADDR_W          = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR    = 32'hbfc00000,
  parameter int                INC             = 4,
  parameter int                MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_address_i,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              rsp_valid,
  output logic              rsp_discard,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              rsp_err
);

  localparam int                CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0]  ONE_CNT = CNT_W'(1);
  localparam logic [ADDR_W-1:0] INC_W   = ADDR_W'(INC);

  logic              ce_reg;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              pending_reg, pending_next;
  logic [ADDR_W-1:0] pending_tgt_reg, pending_tgt_next;
  logic [CNT_W-1:0]  outstanding_reg, outstanding_next;
  logic [CNT_W-1:0]  stale_reg, stale_next;
  logic              err_reg, err_next;
  logic              accept;
  logic              rsp_ok;

  // Request handshake and response classification.
  always_comb begin
    req_valid   = ce_reg & ~stall & ~flush & (outstanding_reg < MAX_CNT);
    accept      = req_valid & req_ready;
    // A response only retires a request if one is actually in flight.
    rsp_ok      = rsp_valid & (outstanding_reg != '0);
    rsp_discard = rsp_valid & (stale_reg != '0);
  end

  // Next-state computation for PC, pending branch and response tracking.
  always_comb begin
    pc_next          = pc_reg;
    pending_next     = pending_reg;
    pending_tgt_next = pending_tgt_reg;
    outstanding_next = outstanding_reg;
    stale_next       = stale_reg;
    err_next         = err_reg | (rsp_valid & (outstanding_reg == '0));

    if (!ce_reg) begin
      pc_next = RESET_VECTOR;
    end else if (flush) begin
      pc_next      = new_pc;
      pending_next = 1'b0;
    end else if (accept) begin
      if (branch_flag_i)    pc_next = branch_target_address_i;
      else if (pending_reg) pc_next = pending_tgt_reg;
      else                  pc_next = pc_reg + INC_W;
      pending_next = 1'b0;
    end else if (branch_flag_i) begin
      // Newest branch wins until a request is accepted.
      pending_next     = 1'b1;
      pending_tgt_next = branch_target_address_i;
    end

    // accept only happens below MAX_CNT, so this never overflows.
    if (accept && !rsp_ok)      outstanding_next = outstanding_reg + ONE_CNT;
    else if (!accept && rsp_ok) outstanding_next = outstanding_reg - ONE_CNT;

    // stale never exceeds outstanding, so a discard is always an rsp_ok.
    if (flush) begin
      stale_next = rsp_ok ? (outstanding_reg - ONE_CNT) : outstanding_reg;
    end else if (rsp_discard) begin
      stale_next = stale_reg - ONE_CNT;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ce_reg          <= 1'b0;
      pc_reg          <= RESET_VECTOR;
      pending_reg     <= 1'b0;
      pending_tgt_reg <= '0;
      outstanding_reg <= '0;
      stale_reg       <= '0;
      err_reg         <= 1'b0;
    end else begin
      ce_reg          <= 1'b1;
      pc_reg          <= pc_next;
      pending_reg     <= pending_next;
      pending_tgt_reg <= pending_tgt_next;
      outstanding_reg <= outstanding_next;
      stale_reg       <= stale_next;
      err_reg         <= err_next;
    end
  end

  assign pc       = pc_reg;
  assign req_addr = pc_reg;
  assign ce       = ce_reg;
  assign rsp_err  = err_reg;

endmodule

// File: tb/tb_pc_fetch_gen.sv
// tb_pc_fetch_gen: table-driven directed vectors plus hand-written reset
// sequences for pc_fetch_gen (default parameters).
module tb_pc_fetch_gen;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_discard;
  logic [31:0] pc;
  logic        ce;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  pc_fetch_gen dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .req_valid               (req_valid),
    .req_ready               (req_ready),
    .req_addr                (req_addr),
    .rsp_valid               (rsp_valid),
    .rsp_discard             (rsp_discard),
    .pc                      (pc),
    .ce                      (ce),
    .rsp_err                 (rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        br;
    logic [31:0] tgt;
    logic        ready;
    logic        rsp;
    logic        e_valid;
    logic [31:0] e_addr;
    logic        e_disc;
    logic        e_err;
    logic        e_ce;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic st, input logic fl, input logic [31:0] np,
                              input logic br, input logic [31:0] tg, input logic rdy,
                              input logic rsp, input logic ev, input logic [31:0] ea,
                              input logic ed, input logic ee, input logic ec);
    vec_t v;
    v.stall = st; v.flush = fl; v.new_pc = np; v.br = br; v.tgt = tg;
    v.ready = rdy; v.rsp = rsp; v.e_valid = ev; v.e_addr = ea;
    v.e_disc = ed; v.e_err = ee; v.e_ce = ec;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    stall = v.stall; flush = v.flush; new_pc = v.new_pc;
    branch_flag_i = v.br; branch_target_address_i = v.tgt;
    req_ready = v.ready; rsp_valid = v.rsp;
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    chk("req_valid", idx, 32'(req_valid), 32'(v.e_valid));
    chk("req_addr", idx, req_addr, v.e_addr);
    chk("pc", idx, pc, v.e_addr);
    chk("rsp_discard", idx, 32'(rsp_discard), 32'(v.e_disc));
    chk("rsp_err", idx, 32'(rsp_err), 32'(v.e_err));
    chk("ce", idx, 32'(ce), 32'(v.e_ce));
    $display("step %0d: st=%0b fl=%0b br=%0b rdy=%0b rsp=%0b -> valid=%0b addr=%h disc=%0b err=%0b ce=%0b",
             idx, v.stall, v.flush, v.br, v.ready, v.rsp, req_valid, req_addr, rsp_discard, rsp_err, ce);
  endtask

  vec_t idle;

  initial begin
    // stall flush new_pc br tgt ready rsp | valid addr disc err ce
    vecs[0]  = mk(0,0,32'h0,0,32'h0,1,0, 0,32'hbfc00000,0,0,0); // first cycle after release
    vecs[1]  = mk(0,0,32'h0,0,32'h0,1,0, 1,32'hbfc00000,0,0,1);
    vecs[2]  = mk(0,0,32'h0,0,32'h0,1,1, 1,32'hbfc00004,0,0,1); // accept + rsp
    vecs[3]  = mk(0,0,32'h0,0,32'h0,1,0, 1,32'hbfc00008,0,0,1);
    vecs[4]  = mk(0,0,32'h0,0,32'h0,1,0, 0,32'hbfc0000c,0,0,1); // full
    vecs[5]  = mk(0,0,32'h0,0,32'h0,0,1, 0,32'hbfc0000c,0,0,1);
    vecs[6]  = mk(0,0,32'h0,1,32'h80000100,0,0, 1,32'hbfc0000c,0,0,1); // branch captured
    vecs[7]  = mk(0,0,32'h0,0,32'h0,0,0, 1,32'hbfc0000c,0,0,1);
    vecs[8]  = mk(0,0,32'h0,0,32'h0,1,0, 1,32'hbfc0000c,0,0,1); // accept uses pending
    vecs[9]  = mk(0,0,32'h0,0,32'h0,0,1, 0,32'h80000100,0,0,1);
    vecs[10] = mk(0,0,32'h0,0,32'h0,1,0, 1,32'h80000100,0,0,1);
    vecs[11] = mk(0,1,32'hbfc00380,0,32'h0,1,0, 0,32'h80000104,0,0,1); // flush, 2 in flight
    vecs[12] = mk(0,0,32'h0,0,32'h0,1,1, 0,32'hbfc00380,1,0,1);
    vecs[13] = mk(0,0,32'h0,0,32'h0,1,0, 1,32'hbfc00380,0,0,1);
    vecs[14] = mk(0,0,32'h0,0,32'h0,0,1, 0,32'hbfc00384,1,0,1);
    vecs[15] = mk(0,0,32'h0,0,32'h0,0,1, 1,32'hbfc00384,0,0,1); // third response kept
    vecs[16] = mk(0,1,32'h00001000,1,32'h80000200,1,0, 0,32'hbfc00384,0,0,1); // flush+branch
    vecs[17] = mk(0,0,32'h0,0,32'h0,1,0, 1,32'h00001000,0,0,1);
    vecs[18] = mk(0,0,32'h0,0,32'h0,0,1, 1,32'h00001004,0,0,1); // branch was dropped
    vecs[19] = mk(0,0,32'h0,1,32'h80000300,1,0, 1,32'h00001004,0,0,1); // branch on accept
    vecs[20] = mk(1,0,32'h0,1,32'h80000400,1,0, 0,32'h80000300,0,0,1); // stall, capture
    vecs[21] = mk(1,0,32'h0,1,32'h80000500,0,1, 0,32'h80000300,0,0,1); // overwrite
    vecs[22] = mk(0,0,32'h0,0,32'h0,1,0, 1,32'h80000300,0,0,1);
    vecs[23] = mk(0,0,32'h0,0,32'h0,0,1, 1,32'h80000500,0,0,1);
    vecs[24] = mk(0,0,32'h0,0,32'h0,0,1, 1,32'h80000500,0,0,1); // rsp with none outstanding
    vecs[25] = mk(0,0,32'h0,0,32'h0,0,0, 1,32'h80000500,0,1,1);
    vecs[26] = mk(0,0,32'h0,0,32'h0,1,0, 1,32'h80000500,0,1,1);
    vecs[27] = mk(0,0,32'h0,0,32'h0,0,1, 1,32'h80000504,0,1,1);
    vecs[28] = mk(0,1,32'hfffffffc,0,32'h0,0,0, 0,32'h80000504,0,1,1);
    vecs[29] = mk(0,0,32'h0,0,32'h0,1,0, 1,32'hfffffffc,0,1,1);
    vecs[30] = mk(0,0,32'h0,0,32'h0,0,0, 1,32'h00000000,0,1,1); // wrap
    idle = mk(0,0,32'h0,0,32'h0,0,0, 0,32'h0,0,0,0);

    // Reset for two cycles and check the reset state.
    rst = 1'b1;
    drive(idle);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ce", -1, 32'(ce), 32'h0);
    chk("rst_pc", -1, pc, 32'hbfc00000);
    chk("rst_valid", -1, 32'(req_valid), 32'h0);
    chk("rst_err", -1, 32'(rsp_err), 32'h0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i]);
      #1;
      check_vec(i, vecs[i]);
    end

    // Reset mid-operation with a request in flight and rsp_err set.
    @(negedge clk);
    drive(idle);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_ce", 100, 32'(ce), 32'h0);
    chk("midrst_pc", 100, pc, 32'hbfc00000);
    chk("midrst_err", 100, 32'(rsp_err), 32'h0);
    chk("midrst_valid", 100, 32'(req_valid), 32'h0);
    $display("mid-op reset: ce=%0b pc=%h err=%0b", ce, pc, rsp_err);

    // Late response from before reset: tracking was dropped, so it is an error.
    rst = 1'b0;
    rsp_valid = 1'b1;
    #1;
    chk("late_disc", 101, 32'(rsp_discard), 32'h0);
    @(negedge clk);
    rsp_valid = 1'b0;
    #1;
    chk("late_err", 102, 32'(rsp_err), 32'h1);
    chk("late_ce", 102, 32'(ce), 32'h1);
    chk("late_valid", 102, 32'(req_valid), 32'h1);
    $display("post-reset stale rsp: err=%0b ce=%0b valid=%0b", rsp_err, ce, req_valid);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
